// File: rtl/baud_autobaud_ctrl.sv
// Baud divisor controller: measures a 0x55 sync character on rx and
// derives the 16x-oversample divisor, or follows a manual divisor.
module baud_autobaud_ctrl #(
  parameter int DVSR_W       = 11,
  parameter int CNT_W        = 19,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_CYC     = 64,
  parameter int DEFAULT_DVSR = 650,
  parameter int MIN_DVSR     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  input  logic              abort,
  input  logic              manual_en,
  input  logic [DVSR_W-1:0] manual_dvsr,
  output logic [DVSR_W-1:0] dvsr,
  output logic              dvsr_upd,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_F, MEAS, CHECK
  } state_t;

  localparam int IW = $clog2(IDLE_CYC + 1);

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rxs;
  logic                    rxs_d;
  logic                    fall;
  logic [IW-1:0]           idle_cnt;
  logic [CNT_W-1:0]        span;
  logic [CNT_W-1:0]        seg;
  logic [1:0]              nfall;
  logic [CNT_W-1:0]        iv [4];

  logic [CNT_W-1:0]        tol;
  logic                    iv_ok;
  logic [CNT_W:0]          rnd;
  logic [CNT_W:0]          q_w;
  logic                    min_ok;
  logic [DVSR_W-1:0]       d;
  logic                    ovf;

  function automatic logic [CNT_W-1:0] adiff(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Synchronizer resets to idle-high so no false edge follows reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, rx});
      rxs_d  <= rxs;
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = rxs_d & ~rxs;
  assign busy = (state != IDLE);

  assign tol   = iv[0] >> 3;
  assign iv_ok = (adiff(iv[1], iv[0]) <= tol) &&
                 (adiff(iv[2], iv[0]) <= tol) &&
                 (adiff(iv[3], iv[0]) <= tol);

  // span covers 8 bit times = 128 ticks; round to nearest, minus one
  assign rnd    = {1'b0, span} + (CNT_W+1)'(64);
  assign q_w    = rnd >> 7;
  assign min_ok = q_w > (CNT_W+1)'(MIN_DVSR);
  assign d      = DVSR_W'(q_w - (CNT_W+1)'(1));

  assign ovf = (&span) || (&seg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dvsr     <= DVSR_W'(DEFAULT_DVSR);
      dvsr_upd <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      idle_cnt <= '0;
      span     <= '0;
      seg      <= '0;
      nfall    <= '0;
      for (int i = 0; i < 4; i++) iv[i] <= '0;
    end else begin
      dvsr_upd <= 1'b0;
      if (state != IDLE && (abort || manual_en)) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort && !manual_en) begin
              state    <= ARM;
              locked   <= 1'b0;
              err      <= 1'b0;
              idle_cnt <= '0;
              span     <= '0;
              seg      <= '0;
            end
          end
          ARM: begin
            span     <= span + CNT_W'(1);
            idle_cnt <= rxs ? idle_cnt + IW'(1) : '0;
            if (rxs && idle_cnt == IW'(IDLE_CYC - 1))
              state <= WAIT_F;
          end
          WAIT_F: begin
            span <= span + CNT_W'(1);
            if (fall) begin
              state <= MEAS;
              span  <= '0;
              seg   <= '0;
              nfall <= '0;
            end
          end
          MEAS: begin
            span <= span + CNT_W'(1);
            seg  <= seg + CNT_W'(1);
            if (fall) begin
              iv[nfall] <= seg + CNT_W'(1);
              seg       <= '0;
              nfall     <= nfall + 2'd1;
              if (nfall == 2'd3) state <= CHECK;
            end
          end
          CHECK: begin
            state <= IDLE;
            if (iv_ok && min_ok) begin
              dvsr     <= d;
              locked   <= 1'b1;
              dvsr_upd <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
        // Saturation doubles as the detection timeout
        if ((state == ARM || state == WAIT_F ||
             state == MEAS) && ovf) begin
          state <= IDLE;
          err   <= 1'b1;
        end
      end
      if (manual_en) begin
        dvsr     <= manual_dvsr;
        dvsr_upd <= (manual_dvsr != dvsr);
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_autobaud_ctrl.sv
// Directed bench for baud_autobaud_ctrl: frame table plus
// hand-written sequences for manual mode, abort, timeout, reset.
module tb_baud_autobaud_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        manual_en = 1'b0;
  logic [10:0] manual_dvsr = '0;
  logic [10:0] dvsr;
  logic        dvsr_upd, busy, locked, err;

  logic        rx2 = 1'b1;
  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic        man2 = 1'b0;
  logic [10:0] mdv2 = '0;
  logic [10:0] dvsr2;
  logic        upd2, busy2, locked2, err2;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;

  always #5 clk = ~clk;

  baud_autobaud_ctrl dut (
    .clk(clk), .reset(reset), .rx(rx),
    .start(start), .abort(abort),
    .manual_en(manual_en), .manual_dvsr(manual_dvsr),
    .dvsr(dvsr), .dvsr_upd(dvsr_upd),
    .busy(busy), .locked(locked), .err(err)
  );

  baud_autobaud_ctrl #(.CNT_W(12)) u_to (
    .clk(clk), .reset(reset), .rx(rx2),
    .start(start2), .abort(abort2),
    .manual_en(man2), .manual_dvsr(mdv2),
    .dvsr(dvsr2), .dvsr_upd(upd2),
    .busy(busy2), .locked(locked2), .err(err2)
  );

  always @(posedge clk) if (dvsr_upd) upd_cnt++;

  typedef struct {
    int bit_len;
    int k;
    int extra;
    bit pass;
    int exp_dvsr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rx = 1'b1;
    repeat (80) @(negedge clk);
  endtask

  // 0x55 LSB-first with start/stop; bit k may be lengthened by extra
  task automatic drive_frame(input int bl, input int k, input int extra);
    logic [9:0] pat;
    int len;
    pat = 10'b10_0101_0101 << 1;
    pat[9] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx = pat[i];
      len = bl + ((i == k) ? extra : 0);
      repeat (len) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int base;
    tbl[0] = '{1736, 0, 0, 1'b1, 108};
    tbl[1] = '{24, 0, 0, 1'b1, 1};
    tbl[2] = '{16, 0, 0, 1'b0, 1};
    tbl[3] = '{160, 0, 0, 1'b1, 9};
    tbl[4] = '{200, 3, 80, 1'b0, 9};
    tbl[5] = '{200, 3, 50, 1'b1, 12};
    tbl[6] = '{200, 3, 51, 1'b0, 12};
    tbl[7] = '{200, 3, -50, 1'b1, 11};
    tbl[8] = '{2083, 0, 0, 1'b1, 129};

    repeat (3) @(negedge clk);
    chk("rst_dvsr", dvsr, 650);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_upd", dvsr_upd, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_dvsr", dvsr, 650);

    foreach (tbl[i]) begin
      base = upd_cnt;
      pulse_start();
      chk($sformatf("v%0d_busy", i), busy, 1);
      drive_frame(tbl[i].bit_len, tbl[i].k, tbl[i].extra);
      wait_idle($sformatf("v%0d", i), 200);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_dvsr", i), dvsr, tbl[i].exp_dvsr);
      chk($sformatf("v%0d_locked", i), locked, int'(tbl[i].pass));
      chk($sformatf("v%0d_err", i), err, int'(!tbl[i].pass));
      chk($sformatf("v%0d_upd", i), upd_cnt - base,
          tbl[i].pass ? 1 : 0);
    end

    // manual mode
    base = upd_cnt;
    @(negedge clk);
    manual_dvsr = 11'd27;
    manual_en = 1'b1;
    @(negedge clk);
    chk("man_dvsr", dvsr, 27);
    chk("man_locked", locked, 0);
    repeat (3) @(negedge clk);
    chk("man_upd", upd_cnt - base, 1);
    pulse_start();
    chk("man_start_ign", busy, 0);
    manual_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("man_off_dvsr", dvsr, 27);
    chk("man_off_busy", busy, 0);

    // manual_en raised during MEAS
    pulse_start();
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("mm_busy_pre", busy, 1);
    manual_dvsr = 11'd40;
    manual_en = 1'b1;
    @(negedge clk);
    chk("mm_busy", busy, 0);
    chk("mm_dvsr", dvsr, 40);
    chk("mm_err", err, 0);
    manual_en = 1'b0;
    repeat (5) @(negedge clk);

    // abort mid-MEAS after a failed run left err set
    pulse_start();
    drive_frame(16, 0, 0);
    wait_idle("pre_ab", 200);
    chk("pre_ab_err", err, 1);
    pulse_start();
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_err", err, 0);
    chk("ab_dvsr", dvsr, 40);

    // start and abort together from IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", busy, 0);

    // timeout on narrow-counter instance with rx stuck low
    rx2 = 1'b0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    chk("to_busy", busy2, 1);
    for (int n = 0; n < 6000 && busy2; n++) @(negedge clk);
    chk("to_done", busy2, 0);
    chk("to_err", err2, 1);
    chk("to_dvsr", dvsr2, 650);
    chk("to_locked", locked2, 0);

    // asynchronous reset mid-detection
    pulse_start();
    rx = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_dvsr", dvsr, 650);
    chk("ar_busy", busy, 0);
    chk("ar_locked", locked, 0);
    chk("ar_err", err, 0);
    chk("ar_upd", dvsr_upd, 0);
    @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
